pn_seq_gen_param: RTL

//  Parametrised Fibonacci-LFSR PN/PRBS generator with run/pause/load control FSM.

---
 rtl/pn_seq_gen_param.sv | 61 ++++++
 1 files changed

// File: rtl/pn_seq_gen_param.sv
// pn_seq_gen_param: Fibonacci-LFSR PN/PRBS generator with run/pause/load control and wrap strobe.
// Optional single-bit error injection is enabled by defining PN_ERR_INJECT_EN.
module pn_seq_gen_param #(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(7'b0000011),
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             pn_ready,
`ifdef PN_ERR_INJECT_EN
  input  logic             err_inject,
`endif
  output logic             pn_valid,
  output logic             pn_bit,
  output logic [WIDTH-1:0] pn_state,
  output logic             seq_wrap,
  output logic             lockup_err
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t           state;
  logic [WIDTH-1:0] lfsr, seed_reg, lfsr_nx;
  logic             xfer, seed_ok;
  assign pn_valid = state == RUN;
  assign xfer     = pn_valid && pn_ready;
  assign seed_ok  = |seed_in;
  assign lfsr_nx  = {^(lfsr & TAPS), lfsr[WIDTH-1:1]};
  assign pn_state = lfsr;
  // load overrides everything, including a coincident shift
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      lfsr       <= SEED;
      seed_reg   <= SEED;
      seq_wrap   <= 1'b0;
      lockup_err <= 1'b0;
    end else if (load) begin
      state      <= IDLE;
      lfsr       <= seed_ok ? seed_in : SEED;
      seed_reg   <= seed_ok ? seed_in : SEED;
      seq_wrap   <= 1'b0;
      lockup_err <= lockup_err | !seed_ok;
    end else begin
      state    <= stop ? (state == RUN ? PAUSE : state) : start ? RUN : state;
      seq_wrap <= xfer && lfsr_nx == seed_reg;
      if (xfer) lfsr <= lfsr_nx;
    end
`ifdef PN_ERR_INJECT_EN
  logic inj_pending;
  always_ff @(posedge clk or negedge reset)
    if (!reset) inj_pending <= 1'b0;
    else inj_pending <= load ? 1'b0 : err_inject ? 1'b1 : xfer ? 1'b0 : inj_pending;
  assign pn_bit = lfsr[0] ^ inj_pending;
`else
  assign pn_bit = lfsr[0];
`endif
endmodule
